// File: rtl/player_loader_pkg.sv
// Shared types and helpers for the stream-to-buffer loader.
// Length normalisation lives here so software models and RTL agree on the 0/clamp rule.
package player_loader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_t;

    localparam int unsigned DEFAULT_TIME_BITS = 10;
    localparam int unsigned DEFAULT_DATA_BITS = 32;

    function automatic logic [31:0] max_words(input int unsigned tbits);
        return 32'd1 << tbits;
    endfunction

    // A zero length means a full buffer; anything beyond the buffer clamps to it.
    function automatic logic [31:0] norm_length(input logic [31:0] len, input int unsigned tbits);
        logic [31:0] maxw;
        maxw = max_words(tbits);
        return (len == 32'd0 || len > maxw) ? maxw : len;
    endfunction

endpackage

// File: rtl/player_loader.sv
// Loads a valid/ready sample stream into consecutive player buffer addresses from 0,
// reporting completion, short (early s_last) and aborted loads.
//
// state | meaning
// IDLE  | waiting for start; stream not accepted
// LOAD  | accepting samples, one buffer write per handshake
module player_loader
    import player_loader_pkg::*;
#(
    parameter int unsigned timeBits = DEFAULT_TIME_BITS,
    parameter int unsigned dataBits = DEFAULT_DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [timeBits:0]   length,
    input  logic                abort,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [dataBits-1:0] s_data,
    input  logic                s_last,
    output logic                w_enable,
    output logic [timeBits-1:0] w_addr,
    output logic [dataBits-1:0] w_in,
    output logic                busy,
    output logic                done,
    output logic                short,
    output logic                aborted,
    output logic [timeBits:0]   words_written
);

    localparam int unsigned LEN_W = timeBits + 1;

    load_state_t      state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    logic             handshake;

    // Ready depends only on state and abort so upstream never sees a valid->ready loop.
    assign s_ready       = (state == LOAD) && !abort;
    assign handshake     = s_valid && s_ready;
    assign count_inc     = count + 1'b1;
    assign words_written = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            count    <= '0;
            w_enable <= 1'b0;
            w_addr   <= '0;
            w_in     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            short    <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= LEN_W'(norm_length(32'(length), timeBits));
                        count   <= '0;
                        short   <= 1'b0;
                        aborted <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (handshake) begin
                        w_enable <= 1'b1;
                        w_addr   <= count[timeBits-1:0];
                        w_in     <= s_data;
                        count    <= count_inc;
                        if (count_inc == len_q || s_last) begin
                            done  <= 1'b1;
                            short <= s_last && (count_inc < len_q);
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
